// File: rtl/mem_access_unit.sv
// Memory-access stage: passes ALU results to write-back, or runs a req/ack access for ldr/str.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT wait cycles and sets err.
module mem_access_unit #(
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [3:0]      op,
  input  logic [15:0]     alu_out,
  input  logic [15:0]     store_data,
  input  logic [RD_W-1:0] rd,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [15:0]     mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [15:0]     wb_data,
  output logic            err
);

  // Opcode values shared with the decoder's macro_defines.v encoding.
  localparam logic [3:0] OP_LDR = 4'h8;
  localparam logic [3:0] OP_STR = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [RD_W-1:0] pend_rd;
  logic            is_mem;

  assign is_mem = (op == OP_LDR) || (op == OP_STR);
  assign stall  = ((state == IDLE) && in_valid && is_mem) || ((state == WAIT) && !mem_ack);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             expired;
  logic             err_q;

  assign expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= 16'h0000;
      pend_rd   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mem) begin
              mem_addr  <= alu_out;
              mem_wdata <= store_data;
              mem_we    <= (op == OP_STR);
              mem_req   <= 1'b1;
              pend_rd   <= rd;
              state     <= WAIT;
`ifdef MEM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= alu_out;
              wb_rd    <= rd;
              wb_en    <= (op != OP_BEQ);
            end
          end
        end
        WAIT: begin
          // An ack arriving on the expiry cycle still completes normally.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= pend_rd;
            wb_en    <= !mem_we;
            wb_data  <= mem_we ? mem_addr : mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (expired) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= pend_rd;
            wb_en    <= 1'b0;
            wb_data  <= 16'h0000;
            err_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table vectors, hand-written reset/no-ack sequences and a random instruction stream.
// Define MEM_TIMEOUT_EN for both files to exercise the timeout path instead of the indefinite wait.
module tb_mem_access_unit;
  localparam int RD_W = 3;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_LDR = 4'h8, OP_STR = 4'h9, OP_BEQ = 4'hA;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, mem_ack;
  logic [3:0]      op;
  logic [15:0]     alu_out, store_data, mem_rdata;
  logic [RD_W-1:0] rd;
  logic            stall, mem_req, mem_we, wb_valid, wb_en, err;
  logic [15:0]     mem_addr, mem_wdata, wb_data;
  logic [RD_W-1:0] wb_rd;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RD_W(RD_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .alu_out(alu_out),
    .store_data(store_data), .rd(rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour of one retired instruction, straight from the opcode rules.
  function automatic bit ref_is_mem(input logic [3:0] o);
    return (o == OP_LDR) || (o == OP_STR);
  endfunction
  function automatic bit ref_wb_en(input logic [3:0] o);
    return !((o == OP_STR) || (o == OP_BEQ));
  endfunction
  function automatic logic [15:0] ref_wb_data(input logic [3:0] o, input logic [15:0] a,
                                              input logic [15:0] rdat);
    return (o == OP_LDR) ? rdat : a;
  endfunction

  typedef struct {
    logic [3:0]      op;
    logic [15:0]     alu;
    logic [15:0]     sd;
    logic [RD_W-1:0] r;
    int              ackd;
    logic [15:0]     rdata;
    logic            exp_en;
    logic [15:0]     exp_data;
  } vec_t;

  // Issue one instruction at a negedge and follow it to retirement; ends at a negedge.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] sd, input logic [RD_W-1:0] r, input int ackd,
                        input logic [15:0] rdat, input logic exp_en, input logic [15:0] exp_data);
    bit m;
    m = ref_is_mem(o);
    in_valid = 1'b1; op = o; alu_out = a; store_data = sd; rd = r; mem_ack = 1'b0;
    #1 check({tag, ".stall_accept"}, 32'(stall), 32'(m));
    if (m) begin
      @(negedge clk);
      check({tag, ".req"}, 32'(mem_req), 32'd1);
      check({tag, ".addr"}, 32'(mem_addr), 32'(a));
      check({tag, ".we"}, 32'(mem_we), 32'(o == OP_STR));
      if (o == OP_STR) check({tag, ".wdata"}, 32'(mem_wdata), 32'(sd));
      for (int k = 1; k < ackd; k++) begin
        in_valid = 1'($urandom); op = 4'($urandom); alu_out = 16'($urandom);
        store_data = 16'($urandom); mem_rdata = 16'($urandom);
        #1 check({tag, ".stall_wait"}, 32'(stall), 32'd1);
        @(negedge clk);
        check({tag, ".hold"}, {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, a});
        check({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
      end
      in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = rdat;
      #1 check({tag, ".stall_ack"}, 32'(stall), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; mem_ack = 1'b0;
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, ".wb_en"}, 32'(wb_en), 32'(exp_en));
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(r));
    check({tag, ".wb_data"}, 32'(wb_data), 32'(exp_data));
    check({tag, ".req_low"}, 32'(mem_req), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] last;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; alu_out = '0; store_data = '0; rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    vecs[0] = '{OP_ADD, 16'h1234, 16'h0000, 3'd2, 0, 16'h0000, 1'b1, 16'h1234};
    vecs[1] = '{OP_LDR, 16'h0040, 16'h0000, 3'd5, 3, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[2] = '{OP_STR, 16'h0010, 16'h00AA, 3'd1, 1, 16'h5555, 1'b0, 16'h0010};
    vecs[3] = '{OP_BEQ, 16'h00F0, 16'h0000, 3'd3, 0, 16'h0000, 1'b0, 16'h00F0};
    vecs[4] = '{OP_SUB, 16'hFFFF, 16'h0000, 3'd7, 0, 16'h0000, 1'b1, 16'hFFFF};
    vecs[5] = '{OP_LDR, 16'hFFFF, 16'h0000, 3'd0, 1, 16'h0000, 1'b1, 16'h0000};
    vecs[6] = '{OP_STR, 16'h0000, 16'hFFFF, 3'd6, 4, 16'h1111, 1'b0, 16'h0000};
    vecs[7] = '{OP_OR,  16'h0000, 16'h0000, 3'd4, 0, 16'h0000, 1'b1, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.we", 32'(mem_we), 32'd0);
    check("rst.wb", {wb_valid, wb_en, err, 29'(wb_rd)}, 32'd0);
    check("rst.data", {mem_addr, wb_data}, 32'd0);
    check("rst.wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1 check("idle_ack.stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("idle_ack.wb", 32'(wb_valid), 32'd0);
    check("idle_ack.req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].alu, vecs[i].sd, vecs[i].r,
             vecs[i].ackd, vecs[i].rdata, vecs[i].exp_en, vecs[i].exp_data);

    // wb_valid is a pulse; write-back fields hold
    last = wb_data;
    @(negedge clk);
    check("pulse.valid", 32'(wb_valid), 32'd0);
    check("pulse.hold", 32'(wb_data), 32'(last));

    // Back-to-back non-memory ops retire every cycle
    in_valid = 1'b1; op = OP_ADD; alu_out = 16'hA001; rd = 3'd1;
    #1 check("b2b.stall0", 32'(stall), 32'd0);
    @(negedge clk);
    check("b2b.d0", {15'd0, wb_valid, wb_data}, {15'd0, 1'b1, 16'hA001});
    op = OP_AND; alu_out = 16'hA002; rd = 3'd2;
    #1 check("b2b.stall1", 32'(stall), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.d1", {15'd0, wb_valid, wb_data}, {15'd0, 1'b1, 16'hA002});
    check("b2b.rd1", 32'(wb_rd), 32'd2);

    // Reset mid-access abandons the request; the later ack is ignored
    in_valid = 1'b1; op = OP_LDR; alu_out = 16'h0077; rd = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rstw.req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw.req", 32'(mem_req), 32'd0);
    check("rstw.addr", 32'(mem_addr), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    #1 check("rstw.stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rstw.no_wb", 32'(wb_valid), 32'd0);
    check("rstw.wb_data", 32'(wb_data), 32'd0);
    run_op("rstw.after", OP_ADD, 16'h4321, 16'h0, 3'd6, 0, 16'h0, 1'b1, 16'h4321);

`ifdef MEM_TIMEOUT_EN
    // Unacknowledged load aborts after 16 wait cycles
    in_valid = 1'b1; op = OP_LDR; alu_out = 16'h0123; rd = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("to.req%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("to.nowb%0d", c), 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    check("to.req_drop", 32'(mem_req), 32'd0);
    check("to.wb", {wb_valid, wb_en, err}, {1'b1, 1'b0, 1'b1});
    check("to.data", 32'(wb_data), 32'd0);
    run_op("to.after", OP_ADD, 16'h0202, 16'h0, 3'd2, 0, 16'h0, 1'b1, 16'h0202);
    check("to.err_sticky", 32'(err), 32'd1);
    // Ack on the expiry cycle completes normally
    in_valid = 1'b1; op = OP_LDR; alu_out = 16'h0124; rd = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    @(negedge clk);
    mem_ack = 1'b0;
    check("to.edge_ack", {15'd0, wb_en, wb_data}, {15'd0, 1'b1, 16'hC0DE});
    do_reset();
    check("to.err_clear", 32'(err), 32'd0);
`else
    // Without the timeout the access waits indefinitely
    in_valid = 1'b1; op = OP_LDR; alu_out = 16'h0123; rd = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("nto.req", 32'(mem_req), 32'd1);
    check("nto.wb", {wb_valid, err}, 2'b00);
    mem_ack = 1'b1; mem_rdata = 16'h7E57;
    @(negedge clk);
    mem_ack = 1'b0;
    check("nto.done", {15'd0, wb_valid, wb_data}, {15'd0, 1'b1, 16'h7E57});
    check("nto.err", 32'(err), 32'd0);
`endif

    // Random instruction stream against the reference rules
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  o;
      logic [15:0] a, sd, rdat;
      logic [RD_W-1:0] r;
      int ad;
      o = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? OP_LDR : OP_STR)
                                      : 4'($urandom);
      a = 16'($urandom); sd = 16'($urandom); rdat = 16'($urandom);
      r = RD_W'($urandom); ad = $urandom_range(1, 4);
      run_op($sformatf("rnd%0d", n), o, a, sd, r, ad, rdat, ref_wb_en(o), ref_wb_data(o, a, rdat));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the 16-bit CPU, directly downstream of the ALU. Consumes the ALU result as a data-memory address for `ldr`/`str`, or passes it through as write-back data for all other ops. Runs a req/ack handshake to data memory, stalls upstream while an access is outstanding, and presents one registered write-back beat per retired instruction.

## Interface
Parameters:
- RD_W, 3: destination register index width
- TIMEOUT, 16: wait cycles before a memory access is aborted (used only with the configuration macro)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  instruction present from the ALU stage
- op  input  4  opcode, `macro_defines.v` encoding
- alu_out  input  16  ALU result (address for `ldr`/`str`)
- store_data  input  16  data for `str`
- rd  input  RD_W  destination register
- stall  output  1  upstream must hold its inputs this cycle
- mem_req  output  1  memory request
- mem_we  output  1  1 = write (`str`), 0 = read
- mem_addr  output  16  memory word address
- mem_wdata  output  16  write data
- mem_ack  input  1  memory completes request this cycle
- mem_rdata  input  16  read data, valid when mem_ack=1
- wb_valid  output  1  one-cycle retire pulse
- wb_en  output  1  register-file write enable, qualified by wb_valid
- wb_rd  output  RD_W  write-back register
- wb_data  output  16  write-back data
- err  output  1  sticky access-timeout flag

## Operation
- States: IDLE, WAIT.
- IDLE, in_valid, op not `ldr`/`str`: next edge wb_valid=1, wb_data=alu_out, wb_rd=rd, wb_en=1 except `str`/`beq` (wb_en=0). State stays IDLE.
- IDLE, in_valid, op `ldr`/`str`: capture alu_out→mem_addr, store_data→mem_wdata, rd, mem_we=(op==`str`); next state WAIT with mem_req=1.
- WAIT: mem_req, mem_addr, mem_wdata, mem_we held stable; in_valid/op ignored. On mem_ack=1: mem_req drops next edge, state→IDLE, wb_valid=1; `ldr`: wb_data=mem_rdata, wb_en=1; `str`: wb_data=mem_addr, wb_en=0.
- stall = (IDLE & in_valid & op is `ldr`/`str`) | (WAIT & ~mem_ack). Combinational.
- mem_ack while IDLE: ignored.
- Addresses are 16-bit word addresses; no alignment check, no wrap logic.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; mem_req, mem_we, wb_valid, wb_en, err = 0; mem_addr, mem_wdata, wb_data = 16'h0000; wb_rd = 0. Applies mid-access: request abandoned, later ack ignored.
- Non-memory op: wb_valid one cycle after acceptance; back-to-back every cycle, no stall.
- Memory op accepted cycle 0: mem_req high from cycle 1; ack in cycle N (N≥1) → wb_valid in cycle N+1. Minimum latency 2 cycles, throughput one memory op per 2 cycles.
- wb_valid is a single-cycle pulse; wb_data/wb_rd/wb_en hold until next retire.

## Configuration
- MEM_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT cycles pass with no mem_ack, mem_req drops, state→IDLE, wb_valid=1 with wb_en=0 and wb_data=0, err set and held until reset. Ack in the same cycle as expiry wins (normal completion).
- Undefined: WAIT lasts indefinitely; err tied 0; no counter logic.

## Test plan
- `add` in_valid, alu_out=16'h1234, rd=2 → next cycle wb_valid=1, wb_en=1, wb_rd=2, wb_data=16'h1234, stall never high.
- `ldr` alu_out=16'h0040, ack 3 cycles after mem_req with mem_rdata=16'hBEEF → mem_addr=16'h0040, mem_we=0, stall high until ack cycle, wb_data=16'hBEEF, wb_en=1 one cycle after ack.
- `str` alu_out=16'h0010, store_data=16'h00AA, ack in first req cycle → mem_we=1, mem_wdata=16'h00AA, wb_valid with wb_en=0, total latency 2.
- rst_n=0 during WAIT, then ack → mem_req=0 after reset edge, no wb_valid, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT=16, `ldr` never acked → mem_req drops after 16 WAIT cycles, wb_valid=1 wb_en=0, err=1 until reset.
